// File: rtl/c2c_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : c2c_master_sequencer
// Purpose  : Chip-to-chip master that sends WORDS 3-bit words to a slave
//            using a four-phase request/ack and valid/ack handshake.
// Revision : 1.0
// ============================================================================
module c2c_master_sequencer #(
    parameter int WORDS   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3*WORDS-1:0] payload,
    input  logic               ack,
    output logic               request,
    output logic               valid,
    output logic [2:0]         data_out,
    output logic [1:0]         state,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_HS   = 2'b01;
    localparam logic [1:0] PH_XFER = 2'b10;
    localparam logic [1:0] PH_FIN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_REQ_REL  = 3'd2,
        S_SEND     = 3'd3,
        S_DACK     = 3'd4,
        S_DACK_REL = 3'd5,
        S_FIN      = 3'd6,
        S_ERR      = 3'd7
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic               ack_meta_q, ack_s_q;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [15:0]        timer_q, timer_d;
    logic [3*WORDS-1:0] shadow_q, shadow_d;

    logic               request_q, request_d;
    logic               valid_q, valid_d;
    logic [2:0]         data_q, data_d;
    logic [1:0]         phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_wait;
    logic               timer_hit;
    logic [2:0]         send_word;

    // ------------------------------------------------------------------
    // Next-state logic; a timeout wins over any same-cycle ack_s change.
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d     = fsm_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        in_wait   = (fsm_q == S_REQ) || (fsm_q == S_REQ_REL) ||
                    (fsm_q == S_DACK) || (fsm_q == S_DACK_REL);
        timer_hit = in_wait && (timer_q == TMO_LAST);

        case (fsm_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    shadow_d = payload;
                    idx_d    = '0;
                    fsm_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (timer_hit)    fsm_d = S_ERR;
                else if (ack_s_q) fsm_d = S_REQ_REL;
            end
            S_REQ_REL: begin
                if (timer_hit)     fsm_d = S_ERR;
                else if (!ack_s_q) fsm_d = S_SEND;
            end
            S_SEND: begin
                fsm_d = S_DACK;
            end
            S_DACK: begin
                if (timer_hit)    fsm_d = S_ERR;
                else if (ack_s_q) fsm_d = S_DACK_REL;
            end
            S_DACK_REL: begin
                if (timer_hit) begin
                    fsm_d = S_ERR;
                end else if (!ack_s_q) begin
                    if (idx_q == LAST_IDX) begin
                        fsm_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        fsm_d = S_SEND;
                    end
                end
            end
            S_FIN: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        timer_d = 16'd0;
        if ((fsm_d == fsm_q) && in_wait) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_comb begin
        send_word = 3'b000;
        for (int k = 0; k < WORDS; k++) begin
            if (idx_d == IDXW'(k)) begin
                send_word = shadow_q[3*k +: 3];
            end
        end
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they line up with the state register without any input-to-output path.
    always_comb begin
        request_d = (fsm_d == S_REQ);
        valid_d   = (fsm_d == S_SEND) || (fsm_d == S_DACK);
        data_d    = data_q;
        if (fsm_d == S_SEND) begin
            data_d = send_word;
        end else if (fsm_d == S_ERR) begin
            data_d = 3'b000;
        end
        case (fsm_d)
            S_REQ, S_REQ_REL:               phase_d = PH_HS;
            S_SEND, S_DACK, S_DACK_REL:     phase_d = PH_XFER;
            S_FIN:                          phase_d = PH_FIN;
            default:                        phase_d = PH_IDLE;
        endcase
        busy_d = (fsm_d != S_IDLE) && (fsm_d != S_ERR);
        done_d = (fsm_d == S_FIN);
        err_d  = (fsm_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            idx_q      <= '0;
            timer_q    <= 16'd0;
            shadow_q   <= '0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 3'b000;
            phase_q    <= PH_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            ack_meta_q <= ack;
            ack_s_q    <= ack_meta_q;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            shadow_q   <= shadow_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign request  = request_q;
    assign valid    = valid_q;
    assign data_out = data_q;
    assign state    = phase_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_c2c_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_c2c_master_sequencer
// Purpose  : Self-checking bench with a reactive slave and a word-level model.
// Revision : 1.0
// ============================================================================
module tb_c2c_master_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start_a;
    logic [11:0] payload_a;
    logic        ack_a;
    logic        request_a, valid_a, busy_a, done_a, err_a;
    logic [2:0]  data_a;
    logic [1:0]  state_a;

    logic        start_b;
    logic [2:0]  payload_b;
    logic        ack_b;
    logic        request_b, valid_b, busy_b, done_b, err_b;
    logic [2:0]  data_b;
    logic [1:0]  state_b;

    c2c_master_sequencer #(.WORDS(4), .TIMEOUT(15)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .payload(payload_a), .ack(ack_a),
        .request(request_a), .valid(valid_a), .data_out(data_a), .state(state_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    c2c_master_sequencer #(.WORDS(1), .TIMEOUT(15)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .payload(payload_b), .ack(ack_b),
        .request(request_b), .valid(valid_b), .data_out(data_b), .state(state_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    int n_eval = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave A: follows (request|valid) after dly_a cycles, or a manual level.
    int   dly_a = 3;
    int   scnt_a = 0;
    bit   slave_en = 1'b1;
    logic slave_ack = 1'b0;
    logic man_ack = 1'b0;
    logic want_a;
    assign ack_a = slave_en ? slave_ack : man_ack;

    always @(negedge clk) begin
        want_a = request_a | valid_a;
        if (!slave_en) begin
            slave_ack = man_ack;
            scnt_a = 0;
        end else if (slave_ack != want_a) begin
            scnt_a++;
            if (scnt_a >= dly_a) begin
                slave_ack = want_a;
                scnt_a = 0;
            end
        end else begin
            scnt_a = 0;
        end
    end

    // Slave B: fixed two-cycle response.
    int   scnt_b = 0;
    logic slave_ack_b = 1'b0;
    assign ack_b = slave_ack_b;

    always @(negedge clk) begin
        if (slave_ack_b != (request_b | valid_b)) begin
            scnt_b++;
            if (scnt_b >= 2) begin
                slave_ack_b = request_b | valid_b;
                scnt_b = 0;
            end
        end else begin
            scnt_b = 0;
        end
    end

    // Word-level monitors: one entry per valid assertion.
    logic [2:0] obs_q[$];
    logic [2:0] obs_b[$];
    int   done_cnt = 0, done_cnt_b = 0, stab_err = 0;
    logic pv = 1'b0, pv_b = 1'b0;
    logic [2:0] pd = 3'b000;

    always @(negedge clk) begin
        if (valid_a && !pv) obs_q.push_back(data_a);
        if (valid_a && pv && (data_a != pd)) stab_err++;
        if (done_a) done_cnt++;
        pv = valid_a;
        pd = data_a;
        if (valid_b && !pv_b) obs_b.push_back(data_b);
        if (done_b) done_cnt_b++;
        pv_b = valid_b;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        done_cnt = 0;
        stab_err = 0;
    endtask

    task automatic start_pulse_a(input logic [11:0] pl);
        start_a = 1'b1;
        payload_a = pl;
        tick();
        start_a = 1'b0;
        payload_a = 12'($urandom);
    endtask

    task automatic wait_done_a(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_a) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        check({tag, "_fin_phase"}, 32'(state_a), 32'd3);
    endtask

    task automatic wait_cond_a(input string tag, input bit want_valid, input int target_words);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((target_words > 0 && obs_q.size() >= target_words) ||
                (target_words == 0 && valid_a == want_valid)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_reached"}, 32'(ok), 32'd1);
    endtask

    // Reference: word k of the payload is bits [3k+2:3k], sent in ascending k.
    task automatic check_words_a(input string tag, input logic [11:0] pl, input int n);
        logic [31:0] got, exp;
        check({tag, "_word_count"}, 32'(obs_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            got = (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hFFFF_FFFF;
            exp = (32'(pl) >> (3 * k)) & 32'd7;
            check($sformatf("%s_word%0d", tag, k), got, exp);
        end
    endtask

    task automatic run_xfer_a(input string tag, input logic [11:0] pl, input int d);
        dly_a = d;
        clear_obs();
        start_pulse_a(pl);
        wait_done_a(tag);
        tick();
        check({tag, "_busy_after"}, 32'(busy_a), 32'd0);
        check({tag, "_phase_after"}, 32'(state_a), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_stable"}, 32'(stab_err), 32'd0);
        check_words_a(tag, pl, 4);
    endtask

    task automatic run_xfer_b(input string tag, input logic [2:0] pl);
        bit ok;
        obs_b.delete();
        done_cnt_b = 0;
        start_b = 1'b1;
        payload_b = pl;
        tick();
        start_b = 1'b0;
        payload_b = ~pl;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_b) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        tick();
        check({tag, "_busy_after"}, 32'(busy_b), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt_b), 32'd1);
        check({tag, "_word_count"}, 32'(obs_b.size()), 32'd1);
        check({tag, "_word0"}, (obs_b.size() > 0) ? 32'(obs_b[0]) : 32'hFFFF_FFFF, 32'(pl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt;
        logic [11:0] pl;
        logic [2:0]  last_data;

        rst_n = 1'b0;
        start_a = 1'b0;
        payload_a = '0;
        start_b = 1'b0;
        payload_b = '0;
        man_ack = 1'b0;
        repeat (3) tick();

        check("rst_request", 32'(request_a), 32'd0);
        check("rst_valid",   32'(valid_a),   32'd0);
        check("rst_data",    32'(data_a),    32'd0);
        check("rst_phase",   32'(state_a),   32'd0);
        check("rst_busy",    32'(busy_a),    32'd0);
        check("rst_done",    32'(done_a),    32'd0);
        check("rst_err",     32'(err_a),     32'd0);
        check("rst_b_busy",  32'(busy_b),    32'd0);

        rst_n = 1'b1;
        repeat (2) tick();

        // Directed reference transfer.
        run_xfer_a("dir", 12'b101_100_011_010, 3);

        // Randomized transfers with random slave latency.
        for (int i = 0; i < 6; i++) begin
            run_xfer_a($sformatf("rnd%0d", i), 12'($urandom), int'($urandom_range(1, 5)));
        end

        // Timeout in REQ with ack stuck low, then restart from ERR.
        slave_en = 1'b0;
        man_ack = 1'b0;
        clear_obs();
        start_pulse_a(12'($urandom));
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (err_a) break;
            if (request_a) cnt++;
            tick();
        end
        check("tmo_req_cycles", 32'(cnt), 32'd15);
        check("tmo_err",        32'(err_a), 32'd1);
        check("tmo_request",    32'(request_a), 32'd0);
        check("tmo_phase",      32'(state_a), 32'd0);
        check("tmo_busy",       32'(busy_a), 32'd0);
        pl = 12'($urandom);
        start_pulse_a(pl);
        check("tmo_restart_err", 32'(err_a), 32'd0);
        check("tmo_restart_req", 32'(request_a), 32'd1);
        slave_en = 1'b1;
        wait_done_a("tmo_recover");
        tick();
        check_words_a("tmo_recover", pl, 4);

        // Ack glitch in IDLE must not move the FSM.
        clear_obs();
        slave_en = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (6) tick();
        check("glitch_phase",   32'(state_a), 32'd0);
        check("glitch_busy",    32'(busy_a), 32'd0);
        check("glitch_request", 32'(request_a), 32'd0);
        check("glitch_valid",   32'(valid_a), 32'd0);
        slave_en = 1'b1;

        // Start pulse with a different payload during DACK is ignored.
        dly_a = 4;
        clear_obs();
        pl = 12'($urandom);
        start_pulse_a(pl);
        wait_cond_a("dack_start_valid", 1'b1, 0);
        tick();
        start_a = 1'b1;
        payload_a = ~pl;
        tick();
        start_a = 1'b0;
        wait_done_a("dack_start");
        tick();
        check_words_a("dack_start", pl, 4);
        repeat (20) tick();
        check("dack_start_done_count", 32'(done_cnt), 32'd1);
        check("dack_start_idle_busy",  32'(busy_a), 32'd0);

        // Asynchronous reset during DACK of word 2.
        dly_a = 3;
        clear_obs();
        start_pulse_a(12'($urandom));
        wait_cond_a("mid_rst_word2", 1'b1, 3);
        tick();
        check("mid_rst_in_dack", 32'(valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_request", 32'(request_a), 32'd0);
        check("mid_rst_valid",   32'(valid_a), 32'd0);
        check("mid_rst_data",    32'(data_a), 32'd0);
        check("mid_rst_phase",   32'(state_a), 32'd0);
        check("mid_rst_busy",    32'(busy_a), 32'd0);
        check("mid_rst_err",     32'(err_a), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        run_xfer_a("post_rst", 12'($urandom), 2);

        // Ack stuck high in DACK_REL of word 0 -> timeout, no advance.
        dly_a = 2;
        clear_obs();
        pl = 12'($urandom);
        start_pulse_a(pl);
        wait_cond_a("dackrel_valid_hi", 1'b1, 0);
        wait_cond_a("dackrel_valid_lo", 1'b0, 0);
        man_ack = 1'b1;
        slave_en = 1'b0;
        cnt = 0;
        last_data = 3'b000;
        for (int i = 0; i < 100; i++) begin
            if (err_a) break;
            if (state_a == 2'b10 && !valid_a) begin
                cnt++;
                last_data = data_a;
            end
            tick();
        end
        check("dackrel_cycles",  32'(cnt), 32'd15);
        check("dackrel_err",     32'(err_a), 32'd1);
        check("dackrel_held",    32'(last_data), 32'(pl[2:0]));
        check("dackrel_words",   32'(obs_q.size()), 32'd1);
        check("dackrel_no_done", 32'(done_cnt), 32'd0);
        check("dackrel_data0",   32'(data_a), 32'd0);
        man_ack = 1'b0;
        repeat (3) tick();
        slave_en = 1'b1;
        repeat (5) tick();

        // Single-word configuration.
        run_xfer_b("w1_dir", 3'b111);
        for (int i = 0; i < 3; i++) begin
            run_xfer_b($sformatf("w1_rnd%0d", i), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
